// File: rtl/kernel_a_ctrl_pkg.sv
// Shared definitions for the kernel_A run-level stream controller:
// state encoding and default sizing.
package kernel_a_ctrl_pkg;

    localparam int CNTW_DEF        = 32;
    localparam int MAXINFLIGHT_DEF = 16;
    localparam int CREDW_DEF       = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/kernel_a_credit_ctr.sv
// Up/down count of items issued into the kernel but not yet collected.
// full is registered so a collect frees a credit only from the next cycle.
module kernel_a_credit_ctr #(
    parameter int W    = 5,
    parameter int MAXV = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);

    logic [W-1:0] nxt;

    always_comb begin
        nxt = count;
        if (inc && !dec)
            nxt = count + W'(1);
        else if (dec && !inc)
            nxt = count - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= nxt;
            full  <= (nxt == W'(MAXV));
        end
    end

endmodule

// File: rtl/kernel_a_stream_ctrl.sv
// Run-level sequencer gating source->kernel and kernel->sink handshakes.
// Optional stall watchdog: define KERNEL_A_STREAM_CTRL_WATCHDOG_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing and collecting items
// DRAIN | all items issued, collecting the rest
// DONE  | one-cycle done pulse
// ERR   | watchdog tripped, held until reset (watchdog build only)
module kernel_a_stream_ctrl
    import kernel_a_ctrl_pkg::*;
#(
    parameter int CNTW        = CNTW_DEF,
    parameter int MAXINFLIGHT = MAXINFLIGHT_DEF,
    parameter int CREDW       = CREDW_DEF
`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
    ,parameter int TIMEOUT    = 1024
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] nitems,
    output logic            busy,
    output logic            done,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            snk_valid,
    input  logic            snk_ready,
    output logic [CNTW-1:0] issued,
    output logic [CNTW-1:0] collected
`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
    ,output logic           err
`endif
);

    state_t            state;
    logic [CNTW-1:0]   nitems_q;
    logic [CREDW-1:0]  inflight;
    logic              full;
    logic              g_in;
    logic              g_out;
    logic              fire_in;
    logic              fire_out;
    logic              last_issue;
    logic              last_collect;
    logic              start_ok;

    assign start_ok = (state == IDLE) && start;

    assign g_in      = (state == RUN) && (issued < nitems_q) && !full;
    assign k_ivalid  = src_valid & g_in;
    assign src_ready = k_iready & g_in;
    assign fire_in   = k_ivalid & k_iready;

    assign g_out     = ((state == RUN) || (state == DRAIN)) && (collected < nitems_q);
    assign snk_valid = k_ovalid & g_out;
    assign k_oready  = snk_ready & g_out;
    assign fire_out  = k_ovalid & k_oready;

    // nitems_q is non-zero whenever the gates are open, so the -1 cannot wrap
    assign last_issue   = fire_in  && (issued    == nitems_q - CNTW'(1));
    assign last_collect = fire_out && (collected == nitems_q - CNTW'(1));

    kernel_a_credit_ctr #(
        .W    (CREDW),
        .MAXV (MAXINFLIGHT)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (fire_in),
        .dec   (fire_out),
        .count (inflight),
        .full  (full)
    );

`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            nitems_q  <= '0;
            issued    <= '0;
            collected <= '0;
`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
            err       <= 1'b0;
            stall     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (fire_in)
                issued <= issued + CNTW'(1);
            if (fire_out)
                collected <= collected + CNTW'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        nitems_q  <= nitems;
                        issued    <= '0;
                        collected <= '0;
                        if (nitems == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_issue && last_collect) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_collect) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
                ERR:  state <= ERR;
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef KERNEL_A_STREAM_CTRL_WATCHDOG_EN
            if (fire_out)
                stall <= '0;
            else if (((state == RUN) || (state == DRAIN)) && (inflight != '0)
                     && (stall != SW'(TIMEOUT)))
                stall <= stall + SW'(1);

            // trip overrides any transition computed above
            if (((state == RUN) || (state == DRAIN)) && (stall == SW'(TIMEOUT))) begin
                state <= ERR;
                busy  <= 1'b0;
                done  <= 1'b0;
                err   <= 1'b1;
            end
`endif
        end
    end

    a_no_collect_when_empty: assert property (
        @(posedge clk) disable iff (!rst) !(fire_out && (inflight == '0)));

endmodule
